// File: rtl/mem_mon_pkg.sv
// mem_mon_pkg: shared state type and sizing helper for the memory channel monitor
package mem_mon_pkg;
  typedef enum logic {MON_IDLE, MON_WAIT} mon_state_t;
  function automatic int stall_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/mem_chan_monitor.sv
// mem_chan_monitor: one channel's req/gnt tracker with stability, stall and spurious-response flags
module mem_chan_monitor
  import mem_mon_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MAX_STALL  = 8,
  parameter int CNT_W      = 16,
  parameter int CHK_STABLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             wen,
  input  logic [3:0]       strb,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  wdata,
  input  logic             gnt,
  input  logic             err,
  output logic             viol_stable,
  output logic             viol_stall,
  output logic             viol_spur,
  output logic [CNT_W-1:0] txn_cnt,
  output logic             busy
);
  localparam int SW = stall_w(MAX_STALL);
  mon_state_t state;
  logic [SW-1:0] stall_ctr;
  logic cap_wen;
  logic [3:0] cap_strb;
  logic [XLEN-1:0] cap_addr, cap_wdata;
  logic waiting, changed, at_max;
  always_comb begin
    waiting = state == MON_WAIT;
    at_max = stall_ctr == SW'(MAX_STALL);
    // write payload only matters for a captured write
    changed = CHK_STABLE != 0 && (cap_addr != addr || cap_wen != wen ||
              (cap_wen && (cap_strb != strb || cap_wdata != wdata)));
  end
  assign busy = waiting;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MON_IDLE;
      stall_ctr <= '0;
      txn_cnt <= '0;
      viol_stable <= 1'b0;
      viol_stall <= 1'b0;
      viol_spur <= 1'b0;
      cap_wen <= 1'b0;
      cap_strb <= '0;
      cap_addr <= '0;
      cap_wdata <= '0;
    end else begin
      if (req && gnt) txn_cnt <= txn_cnt + CNT_W'(1);
      if ((gnt || err) && !req) viol_spur <= 1'b1;
      if (waiting && (!req || changed)) viol_stable <= 1'b1;
      if (waiting && !gnt && at_max) viol_stall <= 1'b1;
      if (!waiting && req && !gnt) begin
        state <= MON_WAIT;
        stall_ctr <= SW'(1);
        cap_wen <= wen;
        cap_strb <= strb;
        cap_addr <= addr;
        cap_wdata <= wdata;
      end else if (waiting && (!req || gnt)) state <= MON_IDLE;
      else if (waiting && !at_max) stall_ctr <= stall_ctr + SW'(1);
    end
  end
endmodule

// File: rtl/mem_chan_fairness_monitor.sv
// mem_chan_fairness_monitor: NCH independent req/gnt channel monitors with combined fairness status
module mem_chan_fairness_monitor #(
  parameter int NCH        = 2,
  parameter int XLEN       = 32,
  parameter int MAX_STALL  = 8,
  parameter int CNT_W      = 16,
  parameter int CHK_STABLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       wen,
  input  logic [NCH*4-1:0]     strb,
  input  logic [NCH*XLEN-1:0]  addr,
  input  logic [NCH*XLEN-1:0]  wdata,
  input  logic [NCH-1:0]       gnt,
  input  logic [NCH-1:0]       err,
  output logic [NCH-1:0]       viol_stable,
  output logic [NCH-1:0]       viol_stall,
  output logic [NCH-1:0]       viol_spur,
  output logic [NCH-1:0]       fair_ok,
  output logic [NCH*CNT_W-1:0] txn_cnt,
  output logic [NCH-1:0]       busy
);
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    mem_chan_monitor #(
      .XLEN(XLEN), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W), .CHK_STABLE(CHK_STABLE)
    ) u_mon (
      .clk(clock),
      .rst(reset),
      .req(req[c]),
      .wen(wen[c]),
      .strb(strb[4*c +: 4]),
      .addr(addr[XLEN*c +: XLEN]),
      .wdata(wdata[XLEN*c +: XLEN]),
      .gnt(gnt[c]),
      .err(err[c]),
      .viol_stable(viol_stable[c]),
      .viol_stall(viol_stall[c]),
      .viol_spur(viol_spur[c]),
      .txn_cnt(txn_cnt[CNT_W*c +: CNT_W]),
      .busy(busy[c])
    );
  end
  assign fair_ok = ~(viol_stable | viol_stall | viol_spur);
endmodule
